// File: rtl/arena_grid_arbiter.sv
// -----------------------------------------------------------------------------
// arena_grid_arbiter
//
// Owns the COLS x ROWS arena cell memory (2 bits per cell: 0 empty,
// 1 player-1 trail, 2 wall, 3 player-2 trail). After reset or restart it
// sweeps the whole grid, writing walls on the border and clearing the inside.
// Afterwards it serves atomic check-and-mark requests from two player
// controllers (round-robin on ties) and an independent VGA read port.
//
// Ports:
//   CLOCK_50          system clock, rising edge
//   reset             asynchronous active-high reset, restarts the clear
//   restart           synchronous restart, aborts any operation, starts a clear
//   busy              high while the clear sweep is running
//   pN_req/col/row    player N check-and-mark request and target cell
//   pN_ack/hit        one-cycle completion pulse and collision result
//   vga_col/vga_row   VGA read address (cell units)
//   vga_cell          registered cell value, one cycle after the address
// -----------------------------------------------------------------------------
module arena_grid_arbiter #(
    parameter int COLS      = 80,
    parameter int ROWS      = 60,
    parameter int BORDER    = 2,
    parameter int WALL_CODE = 2
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       restart,
    output logic       busy,
    input  logic       p1_req,
    input  logic [6:0] p1_col,
    input  logic [5:0] p1_row,
    output logic       p1_ack,
    output logic       p1_hit,
    input  logic       p2_req,
    input  logic [6:0] p2_col,
    input  logic [5:0] p2_row,
    output logic       p2_ack,
    output logic       p2_hit,
    input  logic [6:0] vga_col,
    input  logic [5:0] vga_row,
    output logic [1:0] vga_cell
);

    localparam int CELLS = COLS * ROWS;
    localparam logic GRANT_P1 = 1'b0;
    localparam logic GRANT_P2 = 1'b1;

    typedef enum logic [1:0] {CLEAR, IDLE, READ, WRITE} state_t;

    logic [1:0]  mem [0:CELLS-1];

    state_t      state_reg, state_next;
    logic [12:0] clr_idx_reg, clr_idx_next;
    logic [6:0]  clr_col_reg, clr_col_next;
    logic [5:0]  clr_row_reg, clr_row_next;
    logic        grant_reg, grant_next;
    logic        last_grant_reg, last_grant_next;
    logic [6:0]  col_reg, col_next;
    logic [5:0]  row_reg, row_next;
    logic [1:0]  rd_data_reg;
    logic [1:0]  vga_cell_reg;

    logic        mem_we;
    logic [12:0] mem_waddr;
    logic [1:0]  mem_wdata;

    logic [12:0] target_idx, rd_addr, vga_idx;
    logic        target_in_range, vga_in_range;
    logic        cell_hit, clr_wall, clr_last;
    logic        take, pick_p2;

    // Latched player target. Out-of-range targets never touch memory; the
    // read address is parked at 0 so the array is never indexed past its end.
    assign target_idx      = 13'(row_reg) * 13'(COLS) + 13'(col_reg);
    assign target_in_range = (32'(col_reg) < COLS) && (32'(row_reg) < ROWS);
    assign rd_addr         = target_in_range ? target_idx : 13'd0;
    assign cell_hit        = !target_in_range || (rd_data_reg != 2'd0);

    assign vga_idx      = 13'(vga_row) * 13'(COLS) + 13'(vga_col);
    assign vga_in_range = (32'(vga_col) < COLS) && (32'(vga_row) < ROWS);

    assign clr_wall = (32'(clr_row_reg) < BORDER) || (32'(clr_row_reg) >= ROWS - BORDER) ||
                      (32'(clr_col_reg) < BORDER) || (32'(clr_col_reg) >= COLS - BORDER);
    assign clr_last = (32'(clr_idx_reg) == CELLS - 1);

    assign busy     = (state_reg == CLEAR);
    assign vga_cell = vga_cell_reg;

    always_comb begin
        state_next      = state_reg;
        clr_idx_next    = clr_idx_reg;
        clr_col_next    = clr_col_reg;
        clr_row_next    = clr_row_reg;
        grant_next      = grant_reg;
        last_grant_next = last_grant_reg;
        col_next        = col_reg;
        row_next        = row_reg;
        mem_we          = 1'b0;
        mem_waddr       = clr_idx_reg;
        mem_wdata       = 2'd0;
        p1_ack          = 1'b0;
        p1_hit          = 1'b0;
        p2_ack          = 1'b0;
        p2_hit          = 1'b0;
        take            = 1'b0;
        pick_p2         = 1'b0;

        if (restart) begin
            // Restart wins in every state: no ack, no write, sweep from 0.
            state_next   = CLEAR;
            clr_idx_next = 13'd0;
            clr_col_next = 7'd0;
            clr_row_next = 6'd0;
        end else begin
            case (state_reg)
                CLEAR: begin
                    mem_we    = 1'b1;
                    mem_waddr = clr_idx_reg;
                    mem_wdata = clr_wall ? 2'(WALL_CODE) : 2'd0;
                    if (clr_last) begin
                        state_next   = IDLE;
                        clr_idx_next = 13'd0;
                        clr_col_next = 7'd0;
                        clr_row_next = 6'd0;
                    end else begin
                        clr_idx_next = clr_idx_reg + 13'd1;
                        if (32'(clr_col_reg) == COLS - 1) begin
                            clr_col_next = 7'd0;
                            clr_row_next = clr_row_reg + 6'd1;
                        end else begin
                            clr_col_next = clr_col_reg + 7'd1;
                        end
                    end
                end
                IDLE: begin
                    // Only a tie moves the round-robin pointer.
                    if (p1_req && p2_req) begin
                        take            = 1'b1;
                        pick_p2         = (last_grant_reg == GRANT_P1);
                        last_grant_next = pick_p2 ? GRANT_P2 : GRANT_P1;
                    end else if (p1_req || p2_req) begin
                        take    = 1'b1;
                        pick_p2 = p2_req;
                    end
                    if (take) begin
                        state_next = READ;
                        grant_next = pick_p2 ? GRANT_P2 : GRANT_P1;
                        col_next   = pick_p2 ? p2_col : p1_col;
                        row_next   = pick_p2 ? p2_row : p1_row;
                    end
                end
                READ: begin
                    state_next = WRITE;
                end
                WRITE: begin
                    state_next = IDLE;
                    if (!cell_hit) begin
                        mem_we    = 1'b1;
                        mem_waddr = target_idx;
                        mem_wdata = (grant_reg == GRANT_P2) ? 2'd3 : 2'd1;
                    end
                    p1_ack = (grant_reg == GRANT_P1);
                    p1_hit = (grant_reg == GRANT_P1) && cell_hit;
                    p2_ack = (grant_reg == GRANT_P2);
                    p2_hit = (grant_reg == GRANT_P2) && cell_hit;
                end
                default: state_next = CLEAR;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_reg      <= CLEAR;
            clr_idx_reg    <= 13'd0;
            clr_col_reg    <= 7'd0;
            clr_row_reg    <= 6'd0;
            grant_reg      <= GRANT_P1;
            last_grant_reg <= GRANT_P2;
            col_reg        <= 7'd0;
            row_reg        <= 6'd0;
            vga_cell_reg   <= 2'd0;
        end else begin
            state_reg      <= state_next;
            clr_idx_reg    <= clr_idx_next;
            clr_col_reg    <= clr_col_next;
            clr_row_reg    <= clr_row_next;
            grant_reg      <= grant_next;
            last_grant_reg <= last_grant_next;
            col_reg        <= col_next;
            row_reg        <= row_next;
            vga_cell_reg   <= vga_in_range ? mem[vga_idx] : 2'd0;
        end
    end

    // Read-before-write array: a write lands at the end of its cycle and is
    // seen by any read issued in a later cycle.
    always_ff @(posedge CLOCK_50) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
        rd_data_reg <= mem[rd_addr];
    end

endmodule

// File: tb/tb_arena_grid_arbiter.sv
module tb_arena_grid_arbiter;

    logic       CLOCK_50;
    logic       reset;
    logic       restart;
    logic       busy;
    logic       p1_req;
    logic [6:0] p1_col;
    logic [5:0] p1_row;
    logic       p1_ack;
    logic       p1_hit;
    logic       p2_req;
    logic [6:0] p2_col;
    logic [5:0] p2_row;
    logic       p2_ack;
    logic       p2_hit;
    logic [6:0] vga_col;
    logic [5:0] vga_row;
    logic [1:0] vga_cell;

    int n_assert = 0;
    int n_fail   = 0;

    arena_grid_arbiter dut (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .restart  (restart),
        .busy     (busy),
        .p1_req   (p1_req),
        .p1_col   (p1_col),
        .p1_row   (p1_row),
        .p1_ack   (p1_ack),
        .p1_hit   (p1_hit),
        .p2_req   (p2_req),
        .p2_col   (p2_col),
        .p2_row   (p2_row),
        .p2_ack   (p2_ack),
        .p2_hit   (p2_hit),
        .vga_col  (vga_col),
        .vga_row  (vga_row),
        .vga_cell (vga_cell)
    );

    initial CLOCK_50 = 1'b0;
    always #10 CLOCK_50 = ~CLOCK_50;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic vga_read(input int c, input int r, output logic [1:0] v);
        vga_col = 7'(c);
        vga_row = 6'(r);
        tick();
        v = vga_cell;
        $display("vga read (%0d,%0d) -> %0d", c, r, v);
    endtask

    task automatic vga_chk(input string tag, input int c, input int r, input int exp);
        logic [1:0] v;
        vga_read(c, r, v);
        chk(tag, 32'(v), 32'(exp));
    endtask

    // Full sweep from index 0: busy must stay high for 4799 edges and fall on
    // the 4800th; no player may be acked meanwhile.
    task automatic clear_check(input string tag);
        int acks;
        acks = 0;
        for (int i = 1; i < 4800; i++) begin
            tick();
            if (p1_ack || p2_ack) acks++;
        end
        chk({tag, "_busy_4799"}, 32'(busy), 32'd1);
        tick();
        chk({tag, "_busy_4800"}, 32'(busy), 32'd0);
        chk({tag, "_no_ack"}, 32'(acks), 32'd0);
        $display("%s clear finished, busy=%0d acks=%0d", tag, busy, acks);
    endtask

    // Drives the selected requests, records edges-to-ack and hits, and drops
    // each req one cycle after its ack (bounded at 12 edges).
    task automatic do_ops(input logic e1, input int c1, input int r1,
                          input logic e2, input int c2, input int r2,
                          output int lat1, output int lat2,
                          output logic h1, output logic h2);
        logic drop1, drop2;
        lat1 = 0; lat2 = 0; h1 = 1'bx; h2 = 1'bx;
        drop1 = 1'b0; drop2 = 1'b0;
        p1_col = 7'(c1); p1_row = 6'(r1); p1_req = e1;
        p2_col = 7'(c2); p2_row = 6'(r2); p2_req = e2;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (drop1) p1_req = 1'b0;
            if (drop2) p2_req = 1'b0;
            drop1 = 1'b0; drop2 = 1'b0;
            if (p1_ack) begin lat1 = i; h1 = p1_hit; drop1 = 1'b1; end
            if (p2_ack) begin lat2 = i; h2 = p2_hit; drop2 = 1'b1; end
        end
        p1_req = 1'b0;
        p2_req = 1'b0;
        $display("ops p1(%0d,%0d,req=%0d) lat=%0d hit=%0b | p2(%0d,%0d,req=%0d) lat=%0d hit=%0b",
                 c1, r1, e1, lat1, h1, c2, r2, e2, lat2, h2);
    endtask

    initial begin
        int   l1, l2;
        logic h1, h2;

        reset = 1'b1; restart = 1'b0;
        p1_req = 1'b0; p1_col = '0; p1_row = '0;
        p2_req = 1'b0; p2_col = '0; p2_row = '0;
        vga_col = '0; vga_row = '0;

        // Reset state
        #5;
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_p1_ack", 32'(p1_ack), 32'd0);
        chk("rst_p2_ack", 32'(p2_ack), 32'd0);
        chk("rst_vga", 32'(vga_cell), 32'd0);
        repeat (3) tick();
        reset = 1'b0;
        clear_check("init");

        // Border / interior contents and out-of-range VGA
        vga_chk("vga_c0r0", 0, 0, 2);
        vga_chk("vga_c79r1", 79, 1, 2);
        vga_chk("vga_c2r2", 2, 2, 0);
        vga_chk("vga_c77r57", 77, 57, 0);
        vga_chk("vga_c10r58", 10, 58, 2);
        vga_chk("vga_oor_col", 100, 10, 0);
        vga_chk("vga_oor_row", 5, 62, 0);

        // Single p1 mark, then repeat on the same cell
        do_ops(1'b1, 27, 30, 1'b0, 0, 0, l1, l2, h1, h2);
        chk("p1_first_lat", 32'(l1), 32'd2);
        chk("p1_first_hit", 32'(h1), 32'd0);
        vga_chk("p1_first_cell", 27, 30, 1);
        do_ops(1'b1, 27, 30, 1'b0, 0, 0, l1, l2, h1, h2);
        chk("p1_repeat_lat", 32'(l1), 32'd2);
        chk("p1_repeat_hit", 32'(h1), 32'd1);
        vga_chk("p1_repeat_cell", 27, 30, 1);

        // Simultaneous pairs: first tie to p1, next tie to p2
        do_ops(1'b1, 30, 30, 1'b1, 40, 40, l1, l2, h1, h2);
        chk("pair1_p1_lat", 32'(l1), 32'd2);
        chk("pair1_p2_lat", 32'(l2), 32'd5);
        chk("pair1_p1_hit", 32'(h1), 32'd0);
        chk("pair1_p2_hit", 32'(h2), 32'd0);
        vga_chk("pair1_cell_p1", 30, 30, 1);
        vga_chk("pair1_cell_p2", 40, 40, 3);
        do_ops(1'b1, 31, 31, 1'b1, 41, 41, l1, l2, h1, h2);
        chk("pair2_p2_lat", 32'(l2), 32'd2);
        chk("pair2_p1_lat", 32'(l1), 32'd5);

        // Wall hit, out-of-range target (would alias idx 890 = (10,11))
        do_ops(1'b0, 0, 0, 1'b1, 1, 10, l1, l2, h1, h2);
        chk("p2_wall_hit", 32'(h2), 32'd1);
        vga_chk("p2_wall_cell", 1, 10, 2);
        do_ops(1'b0, 0, 0, 1'b1, 90, 10, l1, l2, h1, h2);
        chk("p2_oor_lat", 32'(l2), 32'd2);
        chk("p2_oor_hit", 32'(h2), 32'd1);
        vga_chk("p2_oor_alias", 10, 11, 0);

        // Same-cell race; last tie went to p2, so p1 goes first
        do_ops(1'b1, 50, 20, 1'b1, 50, 20, l1, l2, h1, h2);
        chk("race_p1_lat", 32'(l1), 32'd2);
        chk("race_p2_lat", 32'(l2), 32'd5);
        chk("race_p1_hit", 32'(h1), 32'd0);
        chk("race_p2_hit", 32'(h2), 32'd1);
        vga_chk("race_cell", 50, 20, 1);

        // Restart during READ aborts the op; held restart keeps the index at 0
        p1_col = 7'd20; p1_row = 6'd20; p1_req = 1'b1;
        tick();
        restart = 1'b1;
        tick();
        chk("rs_no_ack", 32'(p1_ack), 32'd0);
        chk("rs_busy", 32'(busy), 32'd1);
        p1_req = 1'b0;
        repeat (3) tick();
        chk("rs_held_busy", 32'(busy), 32'd1);
        restart = 1'b0;
        // A request pending through the clear is served once it ends
        p2_col = 7'd60; p2_row = 6'd30; p2_req = 1'b1;
        clear_check("restart");
        tick();
        tick();
        chk("pend_p2_ack", 32'(p2_ack), 32'd1);
        chk("pend_p2_hit", 32'(p2_hit), 32'd0);
        tick();
        p2_req = 1'b0;
        vga_chk("pend_cell", 60, 30, 3);
        vga_chk("rs_cleared_27_30", 27, 30, 0);
        vga_chk("rs_cleared_20_20", 20, 20, 0);

        // Asynchronous reset in the middle of a clear
        restart = 1'b1;
        tick();
        restart = 1'b0;
        vga_col = 7'd0; vga_row = 6'd0;
        repeat (2000) tick();
        chk("mid_busy", 32'(busy), 32'd1);
        chk("mid_vga_before", 32'(vga_cell), 32'd2);
        #3 reset = 1'b1;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'd1);
        chk("mid_rst_vga", 32'(vga_cell), 32'd0);
        chk("mid_rst_p1_ack", 32'(p1_ack), 32'd0);
        chk("mid_rst_p2_ack", 32'(p2_ack), 32'd0);
        tick();
        tick();
        reset = 1'b0;
        clear_check("midreset");

        do_ops(1'b1, 27, 30, 1'b0, 0, 0, l1, l2, h1, h2);
        chk("post_p1_lat", 32'(l1), 32'd2);
        chk("post_p1_hit", 32'(h1), 32'd0);
        vga_chk("post_cell", 27, 30, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/arena_grid_arbiter.md
Name: arena_grid_arbiter

Overview:
Owns the 80x60 arena cell memory. Each cell is 2 bits: 0 empty, 1 player-1 trail, 2 wall, 3 player-2 trail. Sequences a full-grid clear on reset/restart. Arbitrates atomic check-and-mark requests from two player controllers (round-robin) and serves a dedicated VGA read port every cycle. Sits between the player movement FSMs and the pixel colour mux in the top level.

Parameters:
COLS, 80, grid columns (one cell = 8x8 pixels)
ROWS, 60, grid rows
BORDER, 2, wall thickness in cells on each edge
WALL_CODE, 2, cell value written to border cells during clear

Ports:
CLOCK_50  in  1  system clock; all state changes on rising edge
reset  in  1  asynchronous, active-high; forces CLEAR from index 0
restart  in  1  synchronous, active-high; level-sampled each cycle, starts a new clear
busy  out  1  high while in CLEAR
p1_req  in  1  player-1 check-and-mark request; held until p1_ack
p1_col  in  7  target column, stable while p1_req high
p1_row  in  6  target row, stable while p1_req high
p1_ack  out  1  one-cycle completion pulse
p1_hit  out  1  collision result, valid only while p1_ack high
p2_req, p2_col, p2_row, p2_ack, p2_hit: same as p1_* for player 2
vga_col  in  7  VGA read column (next_x/8)
vga_row  in  6  VGA read row (next_y/8)
vga_cell  out  2  registered cell value, 1-cycle latency

Behaviour:
- Reset (async): state=CLEAR, clear index=0, busy=1, p1_ack=p2_ack=0, p1_hit=p2_hit=0, vga_cell=0, last_grant=P2, so P1 wins the first tie.
- Address: idx = row*COLS + col, 13-bit, unsigned.
- FSM states: CLEAR, IDLE, READ, WRITE.
- CLEAR:
  - Writes one cell per cycle in raster order, idx 0 to COLS*ROWS-1.
  - Value is WALL_CODE if row<BORDER, row>=ROWS-BORDER, col<BORDER or col>=COLS-BORDER; otherwise 0.
  - Takes 4800 cycles at default parameters. busy stays high through the last write; the next state is IDLE.
  - Player requests are ignored during CLEAR: no ack, and they stay pending.
- IDLE:
  - Samples p1_req/p2_req.
  - One requester active: grant it.
  - Both active: grant the one not equal to last_grant, then update last_grant.
  - On grant, latch the granted id, col and row, then go to READ. No requests: stay in IDLE.
- READ: issues the memory read at the latched idx, then goes to WRITE.
- WRITE:
  - Cell c is available. hit = (c != 0).
  - If c == 0, write 1 (P1) or 3 (P2).
  - Assert the granted port's ack=1 and hit for exactly this cycle, then go to IDLE.
- Latency: req high at IDLE edge n gives ack high in cycle n+2. Minimum spacing between grants is 3 cycles.
- Requester obligation: drop req in the cycle after ack. A req still high in IDLE is a new request.
- Out-of-range target (col>=COLS or row>=ROWS): no write, ack with hit=1 (treated as wall).
- Occupied cells (1, 2 or 3) are never overwritten by players.
- Same-cell race: the two requests are serialized, so the second requester always gets hit=1.
- VGA port:
  - Independent read every cycle in all states, including CLEAR, where it returns in-progress contents.
  - Out-of-range VGA address returns 0.
  - A write in cycle n is visible to a VGA read issued in cycle n+1.
- restart:
  - Sampled in any state. In READ or WRITE it aborts the operation: no ack, no write.
  - Next state is CLEAR with index=0.
  - restart held high keeps the index at 0 and busy high.
- Asynchronous reset during CLEAR restarts the clear from index 0 immediately.

Test Plan:
- Release reset, wait 4800 cycles -> busy falls exactly then; VGA reads return (c0,r0)=2, (c79,r1)=2, (c2,r2)=0, (c77,r57)=0, (c10,r58)=2.
- p1 req col27/row30 -> p1_ack at +2 cycles with p1_hit=0, then VGA read gives 1. Repeat the same cell -> p1_hit=1 and the cell stays 1.
- p1 and p2 req the same cycle, cells (30,30)/(40,40) -> p1 acked at +2 and p2 at +5. Next simultaneous pair -> p2 acked first.
- p2 req col1/row10 -> p2_hit=1 and the cell stays 2. p2 req col90/row10 -> p2_hit=1 with no memory write. p1 and p2 on the same empty cell -> first requester hit=0, second hit=1, cell holds the first player's code.
- Mark (27,30), then assert restart during READ of a new p1 op -> no p1_ack, busy=1. After 4800 cycles (27,30) reads 0.
- Assert reset mid-CLEAR (index ~2000) -> busy=1 and outputs zeroed without waiting for a clock edge. The clear completes 4800 cycles after release.
